// File: rtl/inst_rom.sv
// inst_rom: synchronous instruction memory with a one-cycle fetch port and a
// streaming program-load port. Fetch and load are mutually exclusive: while
// a load is in progress the block is busy and fetch requests are refused.
module inst_rom #(
    parameter int PC_LENGTH   = 32,
    parameter int INST_LENGTH = 32,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_LENGTH-1:0]   pc,
    input  logic                   romCe,
    output logic [INST_LENGTH-1:0] inst,
    output logic                   instValid,
    output logic                   addrErr,
    output logic                   busy,
    input  logic                   ldStart,
    input  logic                   ldValid,
    input  logic [INST_LENGTH-1:0] ldData,
    input  logic                   ldLast,
    output logic                   ldReady,
    output logic [DEPTH_LOG2:0]    ldCount
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Index of the last word; reaching it while loading ends the load.
    localparam logic [DEPTH_LOG2:0] LAST_IDX = {1'b0, {DEPTH_LOG2{1'b1}}};

    // Byte size of the memory, one bit wider than pc so the compare is exact.
    localparam logic [PC_LENGTH:0] ROM_BYTES =
        {{(PC_LENGTH - DEPTH_LOG2 - 2){1'b0}}, 1'b1, {(DEPTH_LOG2 + 2){1'b0}}};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;

    logic [INST_LENGTH-1:0]   mem_r [0:DEPTH-1];

    logic [INST_LENGTH-1:0]   inst_r;
    logic                     inst_valid_r;
    logic                     addr_err_r;
    logic                     busy_r;
    logic                     ld_ready_r;
    logic [DEPTH_LOG2:0]      ld_count_r;

    logic                     inst_valid_next_s;
    logic                     addr_err_next_s;
    logic                     busy_next_s;
    logic                     ld_ready_next_s;
    logic [DEPTH_LOG2:0]      ld_count_next_s;

    logic [DEPTH_LOG2-1:0]    word_idx_s;
    logic                     in_range_s;
    logic                     fetch_s;
    logic                     ld_accept_s;
    logic                     ld_done_s;

    assign word_idx_s  = pc[DEPTH_LOG2+1:2];
    assign in_range_s  = ({1'b0, pc} < ROM_BYTES) && (pc[1:0] == 2'b00);
    assign fetch_s     = (state_r == ST_RUN) && romCe;
    assign ld_accept_s = (state_r == ST_LOAD) && ldValid && ld_ready_r;
    assign ld_done_s   = ld_accept_s && (ldLast || (ld_count_r == LAST_IDX));

    assign inst      = inst_r;
    assign instValid = inst_valid_r;
    assign addrErr   = addr_err_r;
    assign busy      = busy_r;
    assign ldReady   = ld_ready_r;
    assign ldCount   = ld_count_r;

    // State register: reset returns to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: ldStart enters LOAD, the last/full word returns to RUN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (ldStart) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (ld_done_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Output next-values: fetch status flags and load handshake/count.
    always_comb begin
        inst_valid_next_s = fetch_s;
        addr_err_next_s   = fetch_s && !in_range_s;
        busy_next_s       = busy_r;
        ld_ready_next_s   = ld_ready_r;
        ld_count_next_s   = ld_count_r;
        case (state_r)
            ST_RUN: begin
                if (ldStart) begin
                    busy_next_s     = 1'b1;
                    ld_ready_next_s = 1'b1;
                    ld_count_next_s = {(DEPTH_LOG2 + 1){1'b0}};
                end else begin
                    busy_next_s     = 1'b0;
                    ld_ready_next_s = 1'b0;
                end
            end
            ST_LOAD: begin
                if (ld_accept_s) begin
                    ld_count_next_s = ld_count_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
                end else begin
                    ld_count_next_s = ld_count_r;
                end
                if (ld_done_s) begin
                    busy_next_s     = 1'b0;
                    ld_ready_next_s = 1'b0;
                end else begin
                    busy_next_s     = 1'b1;
                    ld_ready_next_s = 1'b1;
                end
            end
            default: begin
                busy_next_s     = 1'b0;
                ld_ready_next_s = 1'b0;
            end
        endcase
    end

    // Output registers for the status flags and the load counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid_r <= 1'b0;
            addr_err_r   <= 1'b0;
            busy_r       <= 1'b0;
            ld_ready_r   <= 1'b0;
            ld_count_r   <= {(DEPTH_LOG2 + 1){1'b0}};
        end else begin
            inst_valid_r <= inst_valid_next_s;
            addr_err_r   <= addr_err_next_s;
            busy_r       <= busy_next_s;
            ld_ready_r   <= ld_ready_next_s;
            ld_count_r   <= ld_count_next_s;
        end
    end

    // Fetch data register: word on a good request, NOP on a bad one, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_r <= {INST_LENGTH{1'b0}};
        end else if (fetch_s) begin
            if (in_range_s) begin
                inst_r <= mem_r[word_idx_s];
            end else begin
                inst_r <= {INST_LENGTH{1'b0}};
            end
        end
    end

    // Memory write port: one accepted load word per edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && ld_accept_s) begin
            mem_r[ld_count_r[DEPTH_LOG2-1:0]] <= ldData;
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
// Self-checking bench for inst_rom: a reference model predicts every output
// each cycle (queued before the edge, compared after it), with table-driven
// fetch vectors and hand-written load/reset sequences checked against constants.
module tb_inst_rom;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        romCe;
    logic [31:0] inst;
    logic        instValid;
    logic        addrErr;
    logic        busy;
    logic        ldStart;
    logic        ldValid;
    logic [31:0] ldData;
    logic        ldLast;
    logic        ldReady;
    logic [10:0] ldCount;

    inst_rom #(.PC_LENGTH(32), .INST_LENGTH(32), .DEPTH_LOG2(10)) dut (
        .clk(clk), .rst(rst), .pc(pc), .romCe(romCe), .inst(inst),
        .instValid(instValid), .addrErr(addrErr), .busy(busy),
        .ldStart(ldStart), .ldValid(ldValid), .ldData(ldData),
        .ldLast(ldLast), .ldReady(ldReady), .ldCount(ldCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        valid;
        logic        err;
        logic        busy;
        logic        ready;
        logic [10:0] count;
    } exp_t;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        err;
    } vec_t;

    exp_t  sbq[$];
    vec_t  vecs[9];
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model state
    logic        m_load = 1'b0;
    logic [31:0] m_inst = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_ready = 1'b0;
    logic [10:0] m_count = 11'd0;
    logic [31:0] m_mem [0:1023];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", phase, nm, act, expv);
        end
    endtask

    // Advance the model with the currently driven inputs, queue its prediction,
    // clock the DUT, then pop and compare.
    task automatic step();
        exp_t e;
        logic inr;
        if (rst) begin
            m_load = 1'b0; m_inst = 32'h0; m_valid = 1'b0; m_err = 1'b0;
            m_busy = 1'b0; m_ready = 1'b0; m_count = 11'd0;
        end else begin
            if (!m_load && romCe) begin
                inr = (pc < 32'h0000_1000) && (pc[1:0] == 2'b00);
                m_inst  = inr ? m_mem[pc[11:2]] : 32'h0;
                m_valid = 1'b1;
                m_err   = !inr;
            end else begin
                m_valid = 1'b0;
                m_err   = 1'b0;
            end
            if (!m_load) begin
                if (ldStart) begin
                    m_load = 1'b1; m_count = 11'd0; m_busy = 1'b1; m_ready = 1'b1;
                end
            end else if (ldValid) begin
                m_mem[m_count[9:0]] = ldData;
                m_count = m_count + 11'd1;
                if (ldLast || m_count == 11'd1024) begin
                    m_load = 1'b0; m_busy = 1'b0; m_ready = 1'b0;
                end
            end
        end
        e.inst = m_inst; e.valid = m_valid; e.err = m_err;
        e.busy = m_busy; e.ready = m_ready; e.count = m_count;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("inst",      64'(inst),      64'(e.inst));
        check("instValid", 64'(instValid), 64'(e.valid));
        check("addrErr",   64'(addrErr),   64'(e.err));
        check("busy",      64'(busy),      64'(e.busy));
        check("ldReady",   64'(ldReady),   64'(e.ready));
        check("ldCount",   64'(ldCount),   64'(e.count));
    endtask

    task automatic idle();
        romCe = 1'b0; ldStart = 1'b0; ldValid = 1'b0; ldLast = 1'b0;
    endtask

    task automatic fetch_const(input logic [31:0] a, input logic [31:0] want);
        romCe = 1'b1; pc = a;
        step();
        check("fetch_inst",  64'(inst),      64'(want));
        check("fetch_valid", 64'(instValid), 64'd1);
        check("fetch_err",   64'(addrErr),   64'd0);
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
        rst = 1'b1; pc = 32'h0; romCe = 1'b1; ldStart = 1'b0; ldValid = 1'b0;
        ldData = 32'h0; ldLast = 1'b0;

        // Reset values
        phase = "reset";
        step(); step();
        check("inst", 64'(inst), 64'd0);
        check("instValid", 64'(instValid), 64'd0);
        check("addrErr", 64'(addrErr), 64'd0);
        check("busy", 64'(busy), 64'd0);
        check("ldReady", 64'(ldReady), 64'd0);

        // Load three words
        phase = "load3";
        rst = 1'b0; idle(); pc = 32'hFFFF_FFFC;
        ldStart = 1'b1; step();
        check("busy_on", 64'(busy), 64'd1);
        check("ready_on", 64'(ldReady), 64'd1);
        ldStart = 1'b0; ldValid = 1'b1;
        ldData = 32'h2401_0005; step();
        ldData = 32'h2402_0003; step();
        ldData = 32'h0022_1820; ldLast = 1'b1; step();
        check("count3", 64'(ldCount), 64'd3);
        check("busy_off", 64'(busy), 64'd0);
        idle();

        // Table-driven fetch vectors
        phase = "table";
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h2401_0005, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0004, 32'h2402_0003, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0008, 32'h0022_1820, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0022_1820, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0004, 32'h2402_0003, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_1000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            romCe = vecs[i].ce; pc = vecs[i].pc;
            step();
            check($sformatf("v%0d_inst", i),  64'(inst),      64'(vecs[i].inst));
            check($sformatf("v%0d_valid", i), 64'(instValid), 64'(vecs[i].valid));
            check($sformatf("v%0d_err", i),   64'(addrErr),   64'(vecs[i].err));
        end

        // Load with fetches attempted and ldValid gaps; ldStart re-asserted mid-load
        phase = "busyfetch";
        idle(); ldStart = 1'b1; step();
        ldStart = 1'b0; romCe = 1'b1; pc = 32'h0;
        ldValid = 1'b1; ldData = 32'hAAAA_0001; step();
        check("busy_valid", 64'(instValid), 64'd0);
        ldValid = 1'b0; ldData = 32'hBAD0_0000; ldStart = 1'b1; step();
        ldStart = 1'b0;
        ldValid = 1'b1; ldData = 32'hAAAA_0002; step();
        ldValid = 1'b0; ldData = 32'hBAD0_0001; step(); step();
        check("gap_count", 64'(ldCount), 64'd2);
        ldValid = 1'b1; ldData = 32'hAAAA_0003; ldLast = 1'b1; step();
        check("gap_final", 64'(ldCount), 64'd3);
        idle();
        fetch_const(32'h0, 32'hAAAA_0001);
        fetch_const(32'h4, 32'hAAAA_0002);
        fetch_const(32'h8, 32'hAAAA_0003);

        // Full-memory load without ldLast
        phase = "full";
        idle(); ldStart = 1'b1; step();
        ldStart = 1'b0; ldValid = 1'b1; ldLast = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            w = {16'(i), ~16'(i)};
            ldData = w;
            step();
        end
        check("full_count", 64'(ldCount), 64'd1024);
        check("full_busy", 64'(busy), 64'd0);
        ldData = 32'hDEAD_BEEF; step();  // 1025th word, in RUN: ignored
        check("extra_count", 64'(ldCount), 64'd1024);
        idle();
        fetch_const(32'h0000_0FFC, 32'h03FF_FC00);
        fetch_const(32'h0000_0000, 32'h0000_FFFF);

        // Reset mid-load
        phase = "rstload";
        ldStart = 1'b1; step();
        ldStart = 1'b0; ldValid = 1'b1;
        ldData = 32'h1111_1111; step();
        ldData = 32'h2222_2222; step();
        rst = 1'b1; ldData = 32'h3333_3333; step();
        rst = 1'b0; idle();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(ldCount), 64'd0);
        check("rst_ready", 64'(ldReady), 64'd0);
        fetch_const(32'h4, 32'h2222_2222);
        fetch_const(32'h0, 32'h1111_1111);
        fetch_const(32'h8, 32'h0002_FFFD);

        idle(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_rom.md
# inst_rom

Synchronous instruction memory that answers the fetch stage's PC/chip-select requests with one-cycle-latency instruction words. It sits between the fetch stage (which drives `pc` and `romCe`) and the decode stage (which consumes `inst`). It also provides a streaming load port so a testbench or boot controller can write a program image before or between runs. While a load is in progress, fetches are refused.

## Interface
Parameters:
- `PC_LENGTH`, 32, width of the byte address from the fetch stage
- `INST_LENGTH`, 32, instruction word width
- `DEPTH_LOG2`, 10, log2 of the number of words (default 1024 words = 4 KiB)

Ports:
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  reset; synchronous and active-high
- `pc`  in  PC_LENGTH  byte address of the requested instruction
- `romCe`  in  1  fetch request / chip select, active-high
- `inst`  out  INST_LENGTH  fetched instruction word
- `instValid`  out  1  `inst` holds a word for the request sampled on the previous edge
- `addrErr`  out  1  previous request was misaligned or out of range
- `busy`  out  1  load in progress; fetches are refused
- `ldStart`  in  1  begin a program load at word 0
- `ldValid`  in  1  `ldData` carries a word
- `ldData`  in  INST_LENGTH  word to write
- `ldLast`  in  1  qualifies `ldValid`: this is the final word of the load
- `ldReady`  out  1  block accepts a load word this cycle
- `ldCount`  out  DEPTH_LOG2+1  words written by the current or most recent load

## Operation
- The block has two states, RUN and LOAD. Reset state is RUN.
- Word index is `pc[DEPTH_LOG2+1:2]`.
- A request is in range when `pc < 4*2^DEPTH_LOG2` (compare at full `PC_LENGTH` width) and `pc[1:0] == 0`.
- **RUN state, `romCe`=1:**
  - In range: `inst` <= mem[index], `instValid` <= 1, `addrErr` <= 0.
  - Otherwise: `inst` <= 0 (NOP), `instValid` <= 1, `addrErr` <= 1.
- **RUN state, `romCe`=0:** `instValid` <= 0, `addrErr` <= 0, and `inst` holds its last value. The fetch stage's reset PC is 0xFFFFFFFC with `romCe`=0, so no error is raised while it is in reset.
- **RUN to LOAD:** `ldStart`=1 moves to LOAD, sets `ldCount` <= 0 and `busy` <= 1. A fetch presented on that same edge is still served normally.
- **In LOAD:**
  - `ldReady` = 1, as a registered flag.
  - Every edge where `ldValid && ldReady` writes mem[`ldCount`] <= `ldData` and increments `ldCount`.
  - `romCe` is ignored: `instValid` <= 0, `addrErr` <= 0.
  - `ldStart` is ignored.
- **LOAD to RUN:** happens on the edge accepting a word with `ldLast`=1, or the edge accepting word 2^DEPTH_LOG2-1 (memory full). On that edge `ldReady` <= 0 and `busy` <= 0; the final count is left in `ldCount`.
- `ldValid` in RUN is ignored; no write occurs.
- `rst`=1 at any time:
  - returns to RUN;
  - `inst`=0, `instValid`=0, `addrErr`=0, `busy`=0, `ldReady`=0, `ldCount`=0;
  - memory contents are not cleared, so words of an aborted load remain.
- `rst` has priority over every other input on the same edge.

## Timing
- Fetch latency is 1 cycle. A request sampled at edge N has `inst`/`instValid`/`addrErr` valid after edge N, for all of cycle N+1.
- Fully pipelined: one new request per cycle, each answered on the next edge.
- `ldReady` first goes high the cycle after `ldStart` is sampled. The first word can be accepted at edge N+1.
- Load throughput: one word per cycle while `ldValid` is held high.
- Fetches may resume on the edge after the final load word is accepted. That fetch sees the new contents, including the last word written.
- Read-during-write cannot occur, because fetch and load are mutually exclusive by state.
- `ldCount` reaches 2^DEPTH_LOG2 on a full load, which is why it is DEPTH_LOG2+1 bits wide.

## Test plan
- **Reset values:** hold `rst`=1 for 2 cycles with `romCe`=1 and `pc`=0. Required: `inst`=0, `instValid`=0, `addrErr`=0, `busy`=0, `ldReady`=0.
- **Load and fetch:**
  - Stimulus: pulse `ldStart`, then stream 0x24010005, 0x24020003, 0x00221820, with `ldLast` on the third word. Then fetch `pc` = 0, 4, 8 on consecutive cycles.
  - Required: `ldCount`=3, `busy` drops after the third word, and `inst` returns the three words in the three cycles after each request, with `instValid`=1.
- **Error handling:**
  - `pc`=0x00000002: `inst`=0, `addrErr`=1.
  - `pc`=0x00001000: `inst`=0, `addrErr`=1.
  - `romCe`=0 with `pc`=0xFFFFFFFC: `instValid`=0, `addrErr`=0.
- **Busy fetch:** during LOAD, drive `romCe`=1 with `pc`=0. Required: `instValid` stays 0. Insert `ldValid` gaps; required: a write occurs only on cycles where `ldValid`=1.
- **Full memory:** stream 1024 words with `ldLast` never asserted. Required: automatic return to RUN after word 1023, and `ldCount`=1024. A 1025th `ldValid` is ignored; fetching `pc`=0xFFC returns word 1023.
- **Reset mid-load:** assert `rst` after 2 of 5 words. Required: RUN state, `busy`=0, `ldCount`=0, and fetching `pc`=4 returns the second word that was written.
